picomips_ctrl: RTL and testbench

//  Multi-cycle instruction fetch/decode control unit for picoMIPS; the producing end of the ALU func/flags interface.

---
 rtl/picomips_pkg.sv | 76 +++++++
 rtl/picomips_if.sv | 51 +++++
 rtl/alucodes.sv | 13 +
 rtl/picomips_branch_eval.sv | 45 ++++
 rtl/picomips_ctrl.sv | 143 ++++++++++++++
 tb/tb_picomips_ctrl.sv | 290 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/picomips_pkg.sv
// picoMIPS control package: opcodes, FSM states, field positions
// and per-opcode decode helpers.
`include "alucodes.sv"

package picomips_pkg;

  localparam int OPW = 4;

  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_ADDI = 4'd2,
    OP_SUB  = 4'd3,
    OP_SUBI = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_NOR  = 4'd8,
    OP_MOV  = 4'd9,
    OP_MOVI = 4'd10,
    OP_BEQ  = 4'd11,
    OP_BNE  = 4'd12,
    OP_BCS  = 4'd13,
    OP_J    = 4'd14,
    OP_HALT = 4'd15
  } opcode_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_t;

  function automatic int isize(int n, int rbits);
    return OPW + 2 * rbits + n;
  endfunction

  function automatic logic [2:0] func_of(opcode_t op);
    logic [2:0] f;
    f = `RA;
    unique case (op)
      OP_ADD, OP_ADDI: f = `RADD;
      OP_SUB, OP_SUBI: f = `RSUB;
      OP_AND:          f = `RAND;
      OP_OR:           f = `ROR;
      OP_XOR:          f = `RXOR;
      OP_NOR:          f = `RNOR;
      OP_MOV, OP_MOVI: f = `RB;
      default:         f = `RA;
    endcase
    return f;
  endfunction

  function automatic logic b_is_imm(opcode_t op);
    return op inside {OP_ADDI, OP_SUBI, OP_MOVI};
  endfunction

  function automatic logic writes_rd(opcode_t op);
    return op inside {[OP_ADD:OP_MOVI]};
  endfunction

  function automatic logic sets_flags(opcode_t op);
    return op inside {[OP_ADD:OP_NOR]};
  endfunction

  function automatic logic can_ovf(opcode_t op);
    return op inside {[OP_ADD:OP_SUBI]};
  endfunction

endpackage

// File: rtl/picomips_if.sv
// Control-side bus of picoMIPS: imem fetch handshake plus the
// ALU/regfile control and flag return signals.
interface picomips_if #(
  parameter int n     = 8,
  parameter int Psize = 6,
  parameter int Rbits = 3
);

  localparam int Isize = 4 + 2 * Rbits + n;

  logic             imem_req;
  logic [Psize-1:0] imem_addr;
  logic             imem_valid;
  logic [Isize-1:0] imem_data;
  logic [2:0]       alu_func;
  logic             alu_b_sel;
  logic [n-1:0]     imm;
  logic [Rbits-1:0] rd;
  logic [Rbits-1:0] rs;
  logic             reg_we;
  logic [3:0]       alu_flags;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_data,
    output alu_func,
    output alu_b_sel,
    output imm,
    output rd,
    output rs,
    output reg_we,
    input  alu_flags
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_data,
    input  alu_func,
    input  alu_b_sel,
    input  imm,
    input  rd,
    input  rs,
    input  reg_we,
    output alu_flags
  );

endinterface

// File: rtl/alucodes.sv
// picoMIPS ALU function codes shared by the control unit and the ALU.
// Guarded so that a project-wide copy of the same macros takes precedence.
`ifndef ALUCODES_SV
`define ALUCODES_SV
`define RA   3'b000
`define RB   3'b001
`define RADD 3'b010
`define RSUB 3'b011
`define RAND 3'b100
`define ROR  3'b101
`define RXOR 3'b110
`define RNOR 3'b111
`endif

// File: rtl/picomips_branch_eval.sv
// Next-PC logic: conditional branches on the flag register, jumps,
// and sequential increment, all modulo 2**Psize.
module picomips_branch_eval
  import picomips_pkg::*;
#(
  parameter int n     = 8,
  parameter int Psize = 6
) (
  input  opcode_t          op,
  input  logic [3:0]       flagreg,
  input  logic [Psize-1:0] pc,
  input  logic [n-1:0]     imm,
  output logic [Psize-1:0] npc
);

  logic             take;
  logic             is_j;
  logic [Psize-1:0] off;
  logic             unused_bits;

  assign unused_bits = ^{flagreg[FLAG_V], flagreg[FLAG_N], imm};

  always_comb begin
    take = 1'b0;
    unique case (op)
      OP_BEQ:  take = flagreg[FLAG_Z];
      OP_BNE:  take = !flagreg[FLAG_Z];
      OP_BCS:  take = flagreg[FLAG_C];
      default: take = 1'b0;
    endcase
  end

  assign is_j = (op == OP_J);
  assign off  = Psize'($signed(imm));

  always_comb begin
    npc = pc + Psize'(1);
    unique case (1'b1)
      take:    npc = pc + off;
      is_j:    npc = Psize'(imm);
      default: npc = pc + Psize'(1);
    endcase
  end

endmodule

// File: rtl/picomips_ctrl.sv
// picoMIPS multi-cycle fetch/decode/exec control unit.
// Build option: PICOMIPS_OVF_TRAP_EN enables the signed-overflow trap.
module picomips_ctrl
  import picomips_pkg::*;
#(
  parameter int n     = 8,
  parameter int Psize = 6,
  parameter int Rbits = 3
) (
  input  logic        clk,
  input  logic        n_reset,
  picomips_if.master  bus,
  output logic        halted,
  output logic        trap
);

  localparam int Isize = isize(n, Rbits);
  localparam int RD_HI = Isize - OPW - 1;
  localparam int RS_HI = RD_HI - Rbits;

  state_t           state;
  state_t           state_n;
  logic [Psize-1:0] pc;
  logic [Psize-1:0] pc_n;
  logic [Psize-1:0] npc;
  logic [3:0]       flagreg;
  logic [Isize-1:0] ir;

  opcode_t          ir_op;
  logic [Rbits-1:0] ir_rd;
  logic [Rbits-1:0] ir_rs;
  logic [n-1:0]     ir_imm;

  opcode_t          op_q;
  logic [2:0]       func_q;
  logic             bsel_q;
  logic [n-1:0]     imm_q;
  logic [Rbits-1:0] rd_q;
  logic [Rbits-1:0] rs_q;
  logic             ovf;

  assign ir_op  = opcode_t'(ir[Isize-1 -: OPW]);
  assign ir_rd  = ir[RD_HI -: Rbits];
  assign ir_rs  = ir[RS_HI -: Rbits];
  assign ir_imm = ir[n-1:0];

  picomips_branch_eval #(
    .n     (n),
    .Psize (Psize)
  ) u_branch (
    .op      (op_q),
    .flagreg (flagreg),
    .pc      (pc),
    .imm     (imm_q),
    .npc     (npc)
  );

`ifdef PICOMIPS_OVF_TRAP_EN
  logic trap_q;

  // Overflow is judged on the flags the ALU returns during this EXEC.
  assign ovf  = (state == EXEC) && can_ovf(op_q)
              && bus.alu_flags[FLAG_V];
  assign trap = trap_q;
`else
  assign ovf  = 1'b0;
  assign trap = 1'b0;
`endif

  always_comb begin
    state_n = state;
    pc_n    = pc;
    unique case (state)
      FETCH: begin
        if (bus.imem_valid) state_n = DECODE;
      end
      DECODE: state_n = EXEC;
      EXEC: begin
        if (ovf || op_q == OP_HALT) begin
          state_n = HALT;
        end else begin
          state_n = FETCH;
          pc_n    = npc;
        end
      end
      HALT:    state_n = HALT;
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state   <= FETCH;
      pc      <= '0;
      flagreg <= '0;
      ir      <= '0;
      op_q    <= OP_NOP;
      func_q  <= `RA;
      bsel_q  <= 1'b0;
      imm_q   <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (state == FETCH && bus.imem_valid) ir <= bus.imem_data;
      if (state == DECODE) begin
        op_q   <= ir_op;
        func_q <= func_of(ir_op);
        bsel_q <= b_is_imm(ir_op);
        imm_q  <= ir_imm;
        rd_q   <= ir_rd;
        rs_q   <= ir_rs;
      end
      if (state == EXEC && sets_flags(op_q)) begin
        flagreg <= bus.alu_flags;
      end
    end
  end

`ifdef PICOMIPS_OVF_TRAP_EN
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      trap_q <= 1'b0;
    end else if (ovf) begin
      trap_q <= 1'b1;
    end
  end
`endif

  // Held low while reset is asserted so nothing leaks out mid-reset.
  assign bus.imem_req  = n_reset && (state == FETCH);
  assign bus.imem_addr = pc;
  assign bus.reg_we    = n_reset && (state == EXEC)
                       && writes_rd(op_q) && !ovf;
  assign bus.alu_func  = func_q;
  assign bus.alu_b_sel = bsel_q;
  assign bus.imm       = imm_q;
  assign bus.rd        = rd_q;
  assign bus.rs        = rs_q;
  assign halted        = (state == HALT);

endmodule

// File: tb/tb_picomips_ctrl.sv
// Directed self-checking bench for picomips_ctrl.
// Exercises fetch handshake, decode, branches, wrap, halt and reset.
module tb_picomips_ctrl;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic halted;
  logic trap;

  int pass = 0;
  int total = 0;

  picomips_if #(.n(8), .Psize(6), .Rbits(3)) bus ();

  picomips_ctrl #(.n(8), .Psize(6), .Rbits(3)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus),
    .halted  (halted),
    .trap    (trap)
  );

  always #5 clk = ~clk;

  logic       o_req_ok;
  logic [5:0] o_addr;
  logic       o_we_other;
  logic       o_we_exec;
  logic [2:0] o_func;
  logic       o_bsel;
  logic [7:0] o_imm;
  logic [2:0] o_rd;
  logic [2:0] o_rs;
  logic       o_trap;

  function automatic logic [17:0] enc(input logic [3:0] op,
                                      input logic [2:0] d,
                                      input logic [2:0] s,
                                      input logic [7:0] i);
    return {op, d, s, i};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds one instruction: dly idle FETCH cycles, then valid, then
  // returns flags fl during EXEC; records what the DUT drove.
  task automatic run(input logic [17:0] ins, input int dly,
                     input logic [3:0] fl);
    o_req_ok   = 1'b1;
    o_addr     = bus.imem_addr;
    o_we_other = 1'b0;
    for (int i = 0; i < dly; i++) begin
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== o_addr) o_req_ok = 1'b0;
      if (bus.reg_we !== 1'b0) o_we_other = 1'b1;
      bus.imem_valid = 1'b0;
      bus.imem_data  = 18'h3ffff;
      tick();
    end
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== o_addr) o_req_ok = 1'b0;
    if (bus.reg_we !== 1'b0) o_we_other = 1'b1;
    bus.imem_valid = 1'b1;
    bus.imem_data  = ins;
    tick();
    bus.imem_valid = 1'b0;
    bus.imem_data  = 18'h3ffff;
    if (bus.reg_we !== 1'b0) o_we_other = 1'b1;
    tick();
    bus.alu_flags = fl;
    #1;
    o_we_exec = bus.reg_we;
    o_func    = bus.alu_func;
    o_bsel    = bus.alu_b_sel;
    o_imm     = bus.imm;
    o_rd      = bus.rd;
    o_rs      = bus.rs;
    o_trap    = trap;
    tick();
    bus.alu_flags = 4'b0000;
  endtask

  task automatic test_reset();
    logic [21:0] v;
    n_reset = 1'b0;
    bus.imem_valid = 1'b1;
    bus.imem_data  = enc(4'd1, 3'd1, 3'd2, 8'h00);
    bus.alu_flags  = 4'b0000;
    tick();
    tick();
    v = {bus.imem_req, bus.reg_we, bus.alu_func, bus.alu_b_sel, bus.imm,
         bus.rd, bus.rs, halted, trap};
    total++;
    if (v !== 22'd0) $display("FAIL reset_outputs: got %h want 0", v);
    else pass++;
    bus.imem_valid = 1'b0;
    n_reset = 1'b1;
    #1;
    total++;
    if (bus.imem_req !== 1'b1) $display("FAIL reset_req: got %b want 1", bus.imem_req);
    else pass++;
    total++;
    if (bus.imem_addr !== 6'd0) $display("FAIL reset_pc: got %0d want 0", bus.imem_addr);
    else pass++;
  endtask

  task automatic test_addi();
    run(enc(4'd2, 3'd1, 3'd0, 8'h05), 0, 4'b0000);
    total++;
    if (o_func !== 3'b010) $display("FAIL addi_func: got %b want 010", o_func);
    else pass++;
    total++;
    if (o_bsel !== 1'b1) $display("FAIL addi_bsel: got %b want 1", o_bsel);
    else pass++;
    total++;
    if (o_imm !== 8'h05 || o_rd !== 3'd1) $display("FAIL addi_fields: got imm %h rd %0d want 05 1", o_imm, o_rd);
    else pass++;
    total++;
    if (o_we_exec !== 1'b1 || o_we_other !== 1'b0) $display("FAIL addi_we: got exec %b other %b want 1 0", o_we_exec, o_we_other);
    else pass++;
    total++;
    if (bus.reg_we !== 1'b0) $display("FAIL addi_we_after: got %b want 0", bus.reg_we);
    else pass++;
    total++;
    if (bus.imem_addr !== 6'd1) $display("FAIL addi_pc: got %0d want 1", bus.imem_addr);
    else pass++;
  endtask

  task automatic test_delay();
    run(enc(4'd1, 3'd2, 3'd3, 8'h00), 4, 4'b0000);
    total++;
    if (o_req_ok !== 1'b1 || o_addr !== 6'd1) $display("FAIL delay_req: got ok %b addr %0d want 1 1", o_req_ok, o_addr);
    else pass++;
    total++;
    if (o_we_other !== 1'b0) $display("FAIL delay_we: got %b want 0", o_we_other);
    else pass++;
    total++;
    if (o_func !== 3'b010 || o_bsel !== 1'b0 || o_rs !== 3'd3) $display("FAIL delay_add: got func %b bsel %b rs %0d want 010 0 3", o_func, o_bsel, o_rs);
    else pass++;
    total++;
    if (bus.imem_addr !== 6'd2) $display("FAIL delay_pc: got %0d want 2", bus.imem_addr);
    else pass++;
  endtask

  task automatic test_branch();
    for (int i = 0; i < 3; i++) run(enc(4'd0, 3'd0, 3'd0, 8'h00), 0, 4'b0000);
    total++;
    if (bus.imem_addr !== 6'd5) $display("FAIL nop_seq_pc: got %0d want 5", bus.imem_addr);
    else pass++;
    run(enc(4'd3, 3'd1, 3'd2, 8'h00), 0, 4'b0010);
    run(enc(4'd11, 3'd0, 3'd0, 8'hFD), 0, 4'b0000);
    total++;
    if (o_func !== 3'b000 || o_we_exec !== 1'b0) $display("FAIL beq_ctl: got func %b we %b want 000 0", o_func, o_we_exec);
    else pass++;
    total++;
    if (bus.imem_addr !== 6'd3) $display("FAIL beq_taken: got %0d want 3", bus.imem_addr);
    else pass++;
    run(enc(4'd0, 3'd0, 3'd0, 8'h00), 0, 4'b0000);
    run(enc(4'd0, 3'd0, 3'd0, 8'h00), 0, 4'b0000);
    run(enc(4'd3, 3'd1, 3'd2, 8'h00), 0, 4'b0010);
    run(enc(4'd12, 3'd0, 3'd0, 8'hFD), 0, 4'b0000);
    total++;
    if (bus.imem_addr !== 6'd7) $display("FAIL bne_not_taken: got %0d want 7", bus.imem_addr);
    else pass++;
    run(enc(4'd11, 3'd0, 3'd0, 8'hFD), 0, 4'b0000);
    total++;
    if (bus.imem_addr !== 6'd4) $display("FAIL branch_keeps_flags: got %0d want 4", bus.imem_addr);
    else pass++;
  endtask

  task automatic test_mov();
    run(enc(4'd3, 3'd1, 3'd2, 8'h00), 0, 4'b0010);
    run(enc(4'd9, 3'd3, 3'd1, 8'h00), 0, 4'b0000);
    total++;
    if (o_func !== 3'b001 || o_bsel !== 1'b0 || o_we_exec !== 1'b1) $display("FAIL mov_ctl: got func %b bsel %b we %b want 001 0 1", o_func, o_bsel, o_we_exec);
    else pass++;
    run(enc(4'd11, 3'd0, 3'd0, 8'h02), 0, 4'b0000);
    total++;
    if (bus.imem_addr !== 6'd8) $display("FAIL mov_keeps_flags: got %0d want 8", bus.imem_addr);
    else pass++;
    run(enc(4'd1, 3'd1, 3'd2, 8'h00), 0, 4'b0001);
    run(enc(4'd13, 3'd0, 3'd0, 8'h03), 0, 4'b0000);
    total++;
    if (bus.imem_addr !== 6'd12) $display("FAIL bcs_taken: got %0d want 12", bus.imem_addr);
    else pass++;
    run(enc(4'd10, 3'd4, 3'd0, 8'h9C), 0, 4'b0000);
    total++;
    if (o_func !== 3'b001 || o_bsel !== 1'b1 || o_imm !== 8'h9C) $display("FAIL movi_ctl: got func %b bsel %b imm %h want 001 1 9c", o_func, o_bsel, o_imm);
    else pass++;
  endtask

  task automatic test_wrap();
    run(enc(4'd14, 3'd0, 3'd0, 8'h3F), 0, 4'b0000);
    total++;
    if (bus.imem_addr !== 6'd63) $display("FAIL j_to_63: got %0d want 63", bus.imem_addr);
    else pass++;
    run(enc(4'd0, 3'd0, 3'd0, 8'h00), 0, 4'b0000);
    total++;
    if (bus.imem_addr !== 6'd0) $display("FAIL pc_wrap: got %0d want 0", bus.imem_addr);
    else pass++;
    run(enc(4'd14, 3'd0, 3'd0, 8'h2A), 0, 4'b0000);
    total++;
    if (bus.imem_addr !== 6'd42) $display("FAIL j_2a: got %0d want 42", bus.imem_addr);
    else pass++;
  endtask

  task automatic test_overflow();
    run(enc(4'd1, 3'd1, 3'd2, 8'h00), 0, 4'b1000);
`ifdef PICOMIPS_OVF_TRAP_EN
    total++;
    if (o_we_exec !== 1'b0) $display("FAIL ovf_we: got %b want 0", o_we_exec);
    else pass++;
    total++;
    if (trap !== 1'b1 || halted !== 1'b1 || bus.imem_req !== 1'b0) $display("FAIL ovf_trap: got trap %b halted %b req %b want 1 1 0", trap, halted, bus.imem_req);
    else pass++;
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
    #1;
`else
    total++;
    if (o_we_exec !== 1'b1 || o_trap !== 1'b0) $display("FAIL ovf_ignored: got we %b trap %b want 1 0", o_we_exec, o_trap);
    else pass++;
    total++;
    if (bus.imem_addr !== 6'd43 || trap !== 1'b0) $display("FAIL ovf_pc: got pc %0d trap %b want 43 0", bus.imem_addr, trap);
    else pass++;
`endif
  endtask

  task automatic test_reset_midfetch();
    run(enc(4'd0, 3'd0, 3'd0, 8'h00), 0, 4'b0000);
    bus.imem_valid = 1'b0;
    tick();
    n_reset = 1'b0;
    bus.imem_valid = 1'b1;
    bus.imem_data  = enc(4'd1, 3'd1, 3'd2, 8'h00);
    tick();
    n_reset = 1'b1;
    bus.imem_valid = 1'b0;
    #1;
    total++;
    if (bus.imem_addr !== 6'd0 || bus.imem_req !== 1'b1) $display("FAIL midreset_pc: got pc %0d req %b want 0 1", bus.imem_addr, bus.imem_req);
    else pass++;
    tick();
    total++;
    if (bus.imem_req !== 1'b1 || bus.alu_func !== 3'b000) $display("FAIL midreset_fetch: got req %b func %b want 1 000", bus.imem_req, bus.alu_func);
    else pass++;
  endtask

  task automatic test_halt();
    logic stuck;
    run(enc(4'd15, 3'd0, 3'd0, 8'h00), 0, 4'b0000);
    total++;
    if (o_we_exec !== 1'b0) $display("FAIL halt_we: got %b want 0", o_we_exec);
    else pass++;
    stuck = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.reg_we !== 1'b0) stuck = 1'b0;
      bus.imem_valid = i[0];
      bus.imem_data  = enc(4'd2, 3'd1, 3'd0, 8'h01);
      tick();
    end
    bus.imem_valid = 1'b0;
    total++;
    if (stuck !== 1'b1) $display("FAIL halt_stays: got %b want 1", stuck);
    else pass++;
    total++;
    if (bus.imem_addr !== 6'd0 || trap !== 1'b0) $display("FAIL halt_pc: got pc %0d trap %b want 0 0", bus.imem_addr, trap);
    else pass++;
  endtask

  initial begin
    bus.imem_valid = 1'b0;
    bus.imem_data  = '0;
    bus.alu_flags  = 4'b0000;
    test_reset();
    test_addi();
    test_delay();
    test_branch();
    test_mov();
    test_wrap();
    test_overflow();
    test_reset_midfetch();
    test_halt();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
